// File: rtl/can_pkg.sv
// Shared widths and the frame record layout used by the CAN RX frame path.
package can_pkg;

  localparam int CAN_ID_W      = 29;
  localparam int CAN_DATA_W    = 64;
  localparam int CAN_LEN_W     = 4;
  localparam int CAN_MAX_BYTES = 8;
  localparam int CAN_FRAME_W   = CAN_ID_W + 1 + CAN_LEN_W + CAN_DATA_W;

  typedef struct packed {
    logic [CAN_ID_W-1:0]   id;
    logic                  ide;
    logic [CAN_LEN_W-1:0]  len;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

endpackage

// File: rtl/can_frame_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head.
// The storage array has no reset and is read synchronously, so it can map to block RAM.
module can_frame_fifo #(
  parameter int WIDTH = 98,
  parameter int ASIZE = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ASIZE;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ASIZE:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             empty, push, pop, bypass;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[ASIZE] != rd_ptr[ASIZE]) &&
                      (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]);
  assign push       = wr_en & ~full;
  assign pop        = rd_ready & ~empty;
  assign wr_ptr_nxt = wr_ptr + {{ASIZE{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{ASIZE{1'b0}}, pop};

  // The entry becoming head is the one being written this very cycle.
  assign bypass = push && (rd_ptr_nxt == wr_ptr);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ASIZE-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      rd_valid <= (wr_ptr_nxt != rd_ptr_nxt);
      if (pop || empty)
        rd_data <= bypass ? wr_data : mem[rd_ptr_nxt[ASIZE-1:0]];
    end
  end

endmodule

// File: rtl/can_rx_frame_assembler.sv
// Reassembles the byte-per-cycle CAN RX stream into frame records and queues them
// for the user; frames that are too long or find the queue full are dropped and counted.
module can_rx_frame_assembler
  import can_pkg::*;
#(
  parameter int FIFO_ASIZE = 3,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [7:0]            in_data,
  input  logic [CAN_ID_W-1:0]   in_id,
  input  logic                  in_ide,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CAN_ID_W-1:0]   out_id,
  output logic                  out_ide,
  output logic [CAN_LEN_W-1:0]  out_len,
  output logic [CAN_DATA_W-1:0] out_data,
  output logic                  drop_pulse,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  // Only seven earlier bytes are ever kept: the eighth reaches a record through the
  // shift path on its own beat, and anything beyond eight bytes is dropped.
  logic [CAN_DATA_W-9:0] acc_data;
  logic [CAN_LEN_W-1:0]  acc_len;
  logic                  acc_err;
  logic [CAN_ID_W-1:0]   acc_id;
  logic                  acc_ide;

  logic                  first_beat, overflow, last_beat, commit, drop, fifo_full;
  logic [CAN_DATA_W-1:0] shifted;
  logic [CAN_LEN_W-1:0]  len_nxt;
  can_frame_t            wr_rec, rd_rec;

  assign first_beat = (acc_len == '0);
  assign overflow   = (acc_len == CAN_LEN_W'(CAN_MAX_BYTES));
  assign shifted    = {acc_data, in_data};
  assign len_nxt    = overflow ? acc_len : acc_len + CAN_LEN_W'(1);
  assign last_beat  = in_valid & in_last;
  assign commit     = last_beat & ~acc_err & ~overflow & ~fifo_full;
  assign drop       = last_beat & ~commit;

  always_comb begin
    wr_rec      = '0;
    wr_rec.id   = first_beat ? in_id  : acc_id;
    wr_rec.ide  = first_beat ? in_ide : acc_ide;
    wr_rec.len  = len_nxt;
    wr_rec.data = shifted;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_data <= '0;
      acc_len  <= '0;
      acc_err  <= 1'b0;
      acc_id   <= '0;
      acc_ide  <= 1'b0;
    end else if (in_valid) begin
      if (in_last) begin
        acc_data <= '0;
        acc_len  <= '0;
        acc_err  <= 1'b0;
      end else begin
        acc_data <= shifted[CAN_DATA_W-9:0];
        acc_len  <= len_nxt;
        acc_err  <= acc_err | overflow;
        if (first_beat) begin
          acc_id  <= in_id;
          acc_ide <= in_ide;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  can_frame_fifo #(
    .WIDTH (CAN_FRAME_W),
    .ASIZE (FIFO_ASIZE)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (commit),
    .wr_data  (wr_rec),
    .full     (fifo_full),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (rd_rec)
  );

  assign out_id   = rd_rec.id;
  assign out_ide  = rd_rec.ide;
  assign out_len  = rd_rec.len;
  assign out_data = rd_rec.data;

endmodule
